// File: rtl/gather_switch_np.sv
// NP-port wormhole gather switch: per-input FIFOs, per-output round-robin
// arbiters that hold a lock for a whole packet, and bad-destination discard.
module gather_switch_np_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          empty_o,
  output logic          full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    wr_d  = push_i ? wr_q + 1'b1 : wr_q;
    rd_d  = pop_i ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the head is only consumed when the FIFO is non-empty.
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= data_i;

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
endmodule

module gather_switch_np #(
  parameter int NP    = 5,
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(NP)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NP-1:0]    in_valid_i,
  input  logic [NP*DW-1:0] in_data_i,
  output logic [NP-1:0]    in_ready_o,
  output logic [NP-1:0]    out_valid_o,
  output logic [NP*DW-1:0] out_data_o,
  input  logic [NP-1:0]    out_ready_i,
  output logic             drop_o,
  output logic [15:0]      drop_cnt_o
);
  localparam logic [1:0] T_HEAD  = 2'b01;
  localparam logic [1:0] T_TAIL  = 2'b10;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BOUND = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [NP-1:0]          f_push, f_pop, f_empty, f_full;
  logic [NP-1:0][DW-1:0]  f_head;
  logic [NP-1:0][1:0]     st_q, st_d;
  logic [NP-1:0]          drop_vec, pop_in, gnt_in, rel_in;
  logic [NP-1:0][NP-1:0]  req;  // req[o][p]
  logic [NP-1:0]          lock_q, lock_d, gnt_vld, fire, rel;
  logic [NP-1:0][PW-1:0]  own_q, own_d, last_q, last_d, gnt_idx;
  logic                   drop_q, drop_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [16:0]            sum;

  assign f_push     = in_valid_i & ~f_full;
  assign in_ready_o = ~f_full;

  for (genvar p = 0; p < NP; p++) begin : g_in
    gather_switch_np_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rstn   (rstn),
      .push_i (f_push[p]),
      .data_i (in_data_i[p*DW +: DW]),
      .pop_i  (f_pop[p]),
      .head_o (f_head[p]),
      .empty_o(f_empty[p]),
      .full_o (f_full[p])
    );
  end

  // Input FSM outputs: requests, discards and drain pops. Type bit DW-2 is set
  // only for head and single flits.
  always_comb begin
    req      = '0;
    drop_vec = '0;
    pop_in   = '0;
    for (int p = 0; p < NP; p++) begin
      if (!f_empty[p]) begin
        if (st_q[p] == S_DRAIN) begin
          pop_in[p] = 1'b1;
        end else if (st_q[p] == S_IDLE) begin
          if (!f_head[p][DW-2]) begin
            pop_in[p] = 1'b1;
          end else if ({1'b0, f_head[p][PW-1:0]} >= (PW+1)'(NP)) begin
            drop_vec[p] = 1'b1;
            pop_in[p]   = 1'b1;
          end else begin
            req[f_head[p][PW-1:0]][p] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    st_d = st_q;
    for (int p = 0; p < NP; p++) begin
      case (st_q[p])
        S_IDLE: begin
          if (drop_vec[p] && f_head[p][DW-1:DW-2] == T_HEAD) st_d[p] = S_DRAIN;
          else if (gnt_in[p])                                 st_d[p] = S_BOUND;
        end
        S_BOUND: if (rel_in[p]) st_d[p] = S_IDLE;
        S_DRAIN: if (!f_empty[p] && f_head[p][DW-1:DW-2] == T_TAIL) st_d[p] = S_IDLE;
        default: st_d[p] = S_IDLE;
      endcase
    end
  end

  // Round-robin search starting one past the last granted input.
  always_comb begin
    int c;
    c       = 0;
    gnt_vld = '0;
    gnt_idx = last_q;
    for (int o = 0; o < NP; o++) begin
      if (!lock_q[o]) begin
        for (int i = 1; i <= NP; i++) begin
          c = int'(last_q[o]) + i;
          if (c >= NP) c = c - NP;
          if (!gnt_vld[o] && req[o][c[PW-1:0]]) begin
            gnt_vld[o] = 1'b1;
            gnt_idx[o] = c[PW-1:0];
          end
        end
      end
    end
  end

  always_comb begin
    out_valid_o = '0;
    out_data_o  = '0;
    fire        = '0;
    rel         = '0;
    rel_in      = '0;
    gnt_in      = '0;
    f_pop       = pop_in;
    for (int o = 0; o < NP; o++) begin
      if (lock_q[o] && !f_empty[own_q[o]]) begin
        out_valid_o[o]           = 1'b1;
        out_data_o[o*DW +: DW]   = f_head[own_q[o]];
      end
      fire[o] = out_valid_o[o] & out_ready_i[o];
      if (fire[o]) begin
        f_pop[own_q[o]] = 1'b1;
        rel[o]          = f_head[own_q[o]][DW-1];
        if (rel[o]) rel_in[own_q[o]] = 1'b1;
      end
      if (gnt_vld[o]) gnt_in[gnt_idx[o]] = 1'b1;
    end
  end

  always_comb begin
    lock_d = lock_q;
    own_d  = own_q;
    last_d = last_q;
    for (int o = 0; o < NP; o++) begin
      if (lock_q[o]) begin
        if (rel[o]) lock_d[o] = 1'b0;
      end else if (gnt_vld[o]) begin
        lock_d[o] = 1'b1;
        own_d[o]  = gnt_idx[o];
        last_d[o] = gnt_idx[o];
      end
    end
  end

  always_comb begin
    sum = {1'b0, cnt_q};
    for (int p = 0; p < NP; p++) sum = sum + 17'(drop_vec[p]);
    cnt_d  = sum[16] ? 16'hFFFF : sum[15:0];
    drop_d = |drop_vec;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q   <= '0;
      lock_q <= '0;
      own_q  <= '0;
      last_q <= {NP{PW'(NP-1)}};
      drop_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      lock_q <= lock_d;
      own_q  <= own_d;
      last_q <= last_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
    end
  end

  assign drop_o     = drop_q;
  assign drop_cnt_o = cnt_q;
endmodule

// File: tb/tb_gather_switch_np.sv
// Randomized + directed bench for gather_switch_np with a queue scoreboard
// keyed by (source, output); flits carry their source port in bits [29:26].
module tb_gather_switch_np;
  localparam int NP = 5, DW = 32, DEPTH = 4;

  logic              clk = 1'b0, rstn = 1'b0;
  logic [NP-1:0]     in_valid = '0, out_ready = '0, in_ready, out_valid;
  logic [NP*DW-1:0]  in_data = '0, out_data;
  logic              drop;
  logic [15:0]       drop_cnt;

  typedef struct { int src; int o; logic [DW-1:0] d; } exp_t;
  typedef struct { int port; logic [DW-1:0] d; } tx_t;
  typedef struct { int cyc; int o; int src; } fire_t;

  exp_t  exp_q[$];
  tx_t   tx_q[$];
  fire_t fire_log[$];
  int errors = 0, checks = 0, cyc = 0, exp_drops = 0, drop_pulses = 0;
  int push_cyc[NP], acc_cnt[NP];
  int cur_src[NP];
  logic [NP-1:0] prev_stall = '0;
  logic [DW-1:0] prev_data[NP];

  gather_switch_np #(.NP(NP), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .out_valid_o(out_valid), .out_data_o(out_data),
    .out_ready_i(out_ready), .drop_o(drop), .drop_cnt_o(drop_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic send_pkt(input int p, input int dest, input int len);
    logic [DW-1:0] f;
    logic [1:0] t;
    for (int i = 0; i < len; i++) begin
      t = (len == 1) ? 2'b11 : (i == 0) ? 2'b01 : (i == len-1) ? 2'b10 : 2'b00;
      f = {t, 4'(p), 23'($urandom), (i == 0) ? 3'(dest) : 3'($urandom)};
      tx_q.push_back('{p, f});
      if (dest < NP) exp_q.push_back('{p, dest, f});
    end
    if (dest >= NP) exp_drops++;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((tx_q.size() != 0 || (|in_valid) || exp_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_timeout"}, longint'(n < budget), 1);
    if (n >= budget) exp_q.delete();
    repeat (6) @(posedge clk);
  endtask

  // Driver: one presented flit per port, advanced after each accepted handshake.
  initial begin : drv
    logic [NP-1:0] acc;
    int k;
    forever begin
      @(negedge clk);
      acc = in_valid & in_ready;
      for (int p = 0; p < NP; p++)
        if (acc[p]) begin
          acc_cnt[p]++;
          if (in_data[p*DW + DW-2]) push_cyc[p] = cyc;
        end
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (acc[p] || !rstn) in_valid[p] = 1'b0;
        if (!in_valid[p] && rstn) begin
          k = -1;
          for (int i = 0; i < tx_q.size(); i++)
            if (k < 0 && tx_q[i].port == p) k = i;
          if (k >= 0) begin
            in_valid[p] = 1'b1;
            in_data[p*DW +: DW] = tx_q[k].d;
            tx_q.delete(k);
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin : mon
    logic [DW-1:0] d;
    int s, k;
    if (!rstn) begin
      prev_stall = '0;
      for (int o = 0; o < NP; o++) cur_src[o] = -1;
    end else begin
      if (drop) drop_pulses++;
      for (int o = 0; o < NP; o++) begin
        d = out_data[o*DW +: DW];
        if (prev_stall[o]) begin
          chk("hold_valid", longint'(out_valid[o]), 1);
          chk("hold_data", longint'(d), longint'(prev_data[o]));
        end
        if (!out_valid[o]) begin
          chk("idle_zero", longint'(d), 0);
        end else if (out_ready[o]) begin
          s = int'(d[29:26]);
          k = -1;
          if (cur_src[o] >= 0) chk("no_interleave", longint'(s), longint'(cur_src[o]));
          for (int i = 0; i < exp_q.size(); i++)
            if (k < 0 && exp_q[i].src == s && exp_q[i].o == o) k = i;
          checks++;
          if (k < 0) begin
            errors++;
            $display("FAIL unexpected_flit out%0d: got %h want none", o, d);
          end else begin
            if (exp_q[k].d !== d) begin
              errors++;
              $display("FAIL flit_data out%0d: got %h want %h", o, d, exp_q[k].d);
            end
            exp_q.delete(k);
          end
          fire_log.push_back('{cyc, o, s});
          cur_src[o] = d[DW-1] ? -1 : s;
        end
        prev_stall[o] = out_valid[o] & ~out_ready[o];
        prev_data[o]  = d;
      end
    end
  end

  initial begin
    int n, first, base, span, np0, np1, s0, s1;
    logic [DW-1:0] head;
    int exp_src[6];
    int exp_off[6];
    exp_src = '{0, 0, 2, 2, 4, 4};
    exp_off = '{0, 1, 3, 4, 6, 7};

    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", longint'(in_ready), longint'({NP{1'b1}}));
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_drop_cnt", longint'(drop_cnt), 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_out_data", longint'(|out_data), 0);
    chk("rst_drop", longint'(drop), 0);

    // single packet, input 1 -> output 3
    out_ready = '1;
    fire_log.delete();
    send_pkt(1, 3, 4);
    wait_idle("t1", 200);
    n = 0;
    for (int i = 0; i < fire_log.size(); i++) if (fire_log[i].o == 3) n++;
    chk("t1_count", longint'(n), 4);
    chk("t1_other", longint'(fire_log.size() - n), 0);
    chk("t1_latency", longint'(fire_log[0].cyc), longint'(push_cyc[1] + 2));
    chk("t1_stream", longint'(fire_log[3].cyc - fire_log[0].cyc), 3);

    // contention on output 1, twice (pointer wraps 4 -> 0)
    for (int r = 0; r < 2; r++) begin
      fire_log.delete();
      send_pkt(0, 1, 2);
      send_pkt(2, 1, 2);
      send_pkt(4, 1, 2);
      wait_idle("t2", 200);
      chk("t2_count", longint'(fire_log.size()), 6);
      first = fire_log[0].cyc;
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("t2_order_r%0d_%0d", r, i), longint'(fire_log[i].src), longint'(exp_src[i]));
        chk($sformatf("t2_gap_r%0d_%0d", r, i), longint'(fire_log[i].cyc - first), longint'(exp_off[i]));
      end
    end

    // parallel paths 0->2 and 3->4
    fire_log.delete();
    send_pkt(0, 2, 4);
    send_pkt(3, 4, 4);
    wait_idle("t3", 200);
    np0 = 0; np1 = 0; s0 = -1; s1 = -1; span = 0;
    for (int i = 0; i < fire_log.size(); i++) begin
      if (fire_log[i].o == 2) begin np0++; if (s0 < 0) s0 = fire_log[i].cyc; span = fire_log[i].cyc - s0; end
      if (fire_log[i].o == 4) begin np1++; if (s1 < 0) s1 = fire_log[i].cyc; end
    end
    chk("t3_count_o2", longint'(np0), 4);
    chk("t3_count_o4", longint'(np1), 4);
    chk("t3_same_start", longint'(s0), longint'(s1));
    chk("t3_rate", longint'(span), 3);

    // backpressure and full FIFO
    out_ready = '1;
    out_ready[2] = 1'b0;
    base = acc_cnt[1];
    send_pkt(1, 2, 10);
    head = tx_q[0].d;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("t4_ready_low", longint'(in_ready[1]), 0);
    chk("t4_accepted", longint'(acc_cnt[1] - base), 4);
    chk("t4_valid", longint'(out_valid[2]), 1);
    chk("t4_hold_head", longint'(out_data[2*DW +: DW]), longint'(head));
    @(posedge clk);
    #1 out_ready[2] = 1'b1;
    wait_idle("t4", 300);
    chk("t4_all_in", longint'(acc_cnt[1] - base), 10);

    // bad destination: head dest 6 (+3 flits), single dest NP, then good packet
    fire_log.delete();
    base = drop_pulses;
    send_pkt(3, 6, 4);
    send_pkt(3, NP, 1);
    send_pkt(3, 0, 3);
    wait_idle("t5", 300);
    chk("t5_drop_cnt", longint'(drop_cnt), longint'(exp_drops));
    chk("t5_drop_pulses", longint'(drop_pulses - base), 2);
    chk("t5_routed", longint'(fire_log.size()), 3);

    // randomized traffic with random downstream readiness
    for (int i = 0; i < 40; i++)
      send_pkt($urandom_range(0, NP-1),
               ($urandom_range(0, 9) == 0) ? $urandom_range(NP, 7) : $urandom_range(0, NP-1),
               $urandom_range(1, 5));
    n = 1;
    fork
      begin
        while (n != 0) begin
          @(posedge clk);
          #1 out_ready = NP'($urandom);
        end
        out_ready = '1;
      end
      begin
        wait_idle("t6", 6000);
        n = 0;
      end
    join
    repeat (4) @(posedge clk);
    chk("t6_drop_cnt", longint'(drop_cnt), longint'(exp_drops));

    // reset mid-packet: head+body buffered for output 0, held by backpressure
    out_ready = '1;
    out_ready[0] = 1'b0;
    tx_q.push_back('{2, {2'b01, 4'd2, 23'($urandom), 3'd0}});
    tx_q.push_back('{2, {2'b00, 4'd2, 23'($urandom), 3'($urandom)}});
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("t7_pre_valid", longint'(out_valid[0]), 1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t7_out_valid", longint'(out_valid), 0);
    chk("t7_out_data", longint'(|out_data), 0);
    chk("t7_in_ready", longint'(in_ready), longint'({NP{1'b1}}));
    chk("t7_drop", longint'(drop), 0);
    chk("t7_drop_cnt", longint'(drop_cnt), 0);
    @(posedge clk);
    #2 rstn = 1'b1;
    out_ready = '1;
    exp_drops = 0;
    fire_log.delete();
    send_pkt(2, 4, 2);
    wait_idle("t7", 200);
    chk("t7_new_pkt", longint'(fire_log.size()), 2);
    chk("t7_no_drop", longint'(drop_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gather_switch_np.md
# gather_switch_np

Parametrised wormhole gather switch for the gather network: NP input ports, each with a DEPTH-flit input FIFO, routed to NP output ports by a destination field in the head flit. Each output has its own round-robin arbiter with a packet lock. Head flits with an out-of-range destination are discarded and counted. It generalises the fixed five-port gather router in port count, flit width and buffer depth. It is also the building block for higher-radix gather trees.

## Interface
Parameters:
- `NP`, 5, number of input ports and output ports (2..16)
- `DW`, 32, flit width; bits [DW-1:DW-2] are the flit type
- `DEPTH`, 4, input FIFO depth per port; must be a power of two, at least 2
- `PW`, $clog2(NP), width of the destination field; the field is head-flit bits [PW-1:0]

Ports:
- `clk`  in  1  clock
- `rstn`  in  1  asynchronous active-low reset
- `in_valid_i`  in  NP  per-port input valid
- `in_data_i`  in  NP*DW  input flits; port p occupies [p*DW +: DW]
- `in_ready_o`  out  NP  per-port input ready, equal to "FIFO not full"
- `out_valid_o`  out  NP  per-port output valid
- `out_data_o`  out  NP*DW  output flits; port o occupies [o*DW +: DW]
- `out_ready_i`  in  NP  per-port downstream ready
- `drop_o`  out  1  one-cycle pulse when a packet with a bad destination is discarded
- `drop_cnt_o`  out  16  saturating count of discarded packets

## Operation
- Flit types:
  - 2'b01 head
  - 2'b00 body
  - 2'b10 tail
  - 2'b11 single (head and tail in one flit)
- Input FIFO: a flit is pushed on `in_valid_i & in_ready_o`. Push and pop can happen in the same cycle; when they do, the occupancy does not change. There is no push while full, and a pop while empty is impossible.
- Each input is in one of three states:
  - IDLE: the FIFO head is not yet bound to an output.
  - BOUND(o): the input is streaming a packet to output o.
  - DRAIN: the input is discarding a packet.
- Input in IDLE with a head or single flit at the FIFO head:
  - If dest ≥ NP, the input goes to DRAIN, `drop_o` pulses and `drop_cnt_o` increments, saturating at 16'hFFFF.
  - Otherwise it requests output dest.
- A body or tail flit at the head of an IDLE input is a protocol error. It is popped and discarded without counting.
- DRAIN: one flit is popped per cycle while the FIFO is non-empty. The input returns to IDLE after popping a tail flit. A single flit pops in the same cycle it is dropped and the input stays IDLE.
- Output arbiter, one per output o, with state FREE or LOCKED(p):
  - FREE: pick among the requesting IDLE inputs in round-robin order, starting at the last granted input + 1, modulo NP. Register LOCKED(p), move input p to BOUND(o), and set the last-granted pointer to p. The reset value of the pointer is NP-1, so input 0 has priority first.
  - LOCKED(p): `out_valid_o[o]` = FIFO p non-empty; `out_data_o[o]` = FIFO p head. On `out_valid_o[o] & out_ready_i[o]`, pop FIFO p.
  - When a tail or single flit fires, the output goes to FREE and input p goes to IDLE, both next cycle.
- Different outputs arbitrate independently in the same cycle. An input can be bound to only one output.
- `out_data_o` for a port is 0 whenever its `out_valid_o` is 0.

## Timing
- Reset values:
  - `in_ready_o` all 1
  - `out_valid_o` all 0
  - `out_data_o` 0
  - `drop_o` 0
  - `drop_cnt_o` 0
  - all FIFOs empty, inputs IDLE, arbiters FREE
- Reset mid-packet discards every buffered flit and every lock immediately.
- Head latency: a flit pushed at cycle t reaches the FIFO head at t+1. The grant is registered at the end of t+1. `out_valid_o` rises at t+2 when downstream is ready.
- Streaming: one flit per cycle per output while the input FIFO is non-empty and `out_ready_i` is high.
- Packet turnaround: there is one idle cycle on an output between a tail fire and the next packet's head.
- `in_ready_o` is combinational from the current occupancy only. It does not look ahead at a pop in the same cycle.
- Backpressure: `out_valid_o` and `out_data_o` hold stable while `out_ready_i` is low.
- `drop_o` is registered and is high for exactly one cycle per discarded head.

## Test plan
- Single packet: NP=5. Input 1 sends head (dest 3), body, body, tail with `out_ready_i` always high. Required: flits appear on output 3 at cycles t+2..t+5 with identical data; no other output goes valid.
- Contention: inputs 0, 2 and 4 all send 2-flit packets to output 1 in the same cycle. Required: output order is 0, 2, 4, with one idle cycle between packets. Repeating the test gives the order 0, 2, 4 again, because the pointer wraps from 4 back to 0.
- Parallel paths: input 0 sends to output 2 while input 3 sends to output 4, at the same time. Required: both streams are sent 1 flit/cycle and do not interleave.
- Backpressure and full: hold `out_ready_i[2]` low while a 10-flit packet arrives with DEPTH=4. Required: `in_ready_o` drops after 4 accepted flits and `out_data_o` holds the head flit. After release all 10 flits arrive in order and none are lost.
- Bad destination: NP=5, head with dest 6 followed by 2 body flits and a tail. Required: one `drop_o` pulse, `drop_cnt_o` = 1, no output valid, the input returns to IDLE, and the next valid packet is routed normally.
- Reset mid-packet: assert `rstn` low after 2 of 4 flits. Required: all outputs go to reset values immediately; after release the first flit accepted is treated as a new packet.
